// File: rtl/cam_stream_gen_pkg.sv
// Shared definitions for the OV7670-style test-pattern stream generator:
// FSM state encoding, pattern codes, RGB565 bar colours and the byte-split helper.
package cam_stream_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } state_t;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_GRAD  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pat_t;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   // Colour of bar idx, left to right across the line.
   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = RGB_WHITE;
         3'd1:    bar_color = RGB_YELLOW;
         3'd2:    bar_color = RGB_CYAN;
         3'd3:    bar_color = RGB_GREEN;
         3'd4:    bar_color = RGB_MAGENTA;
         3'd5:    bar_color = RGB_RED;
         3'd6:    bar_color = RGB_BLUE;
         default: bar_color = RGB_BLACK;
      endcase
   endfunction

   // Even byte carries {R[4:0],G[5:3]}, odd byte carries {G[2:0],B[4:0]}.
   function automatic logic [7:0] rgb_byte(input logic [15:0] rgb, input logic odd);
      rgb_byte = odd ? rgb[7:0] : rgb[15:8];
   endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// Camera-side pixel bus (Pclk/Href/Vsync/Datos) plus the frame_done strobe.
// With CAM_STREAM_GEN_FRAME_CNT_EN defined the bus also carries frame_cnt.
interface cam_stream_gen_if;
   logic       Pclk;
   logic       Href;
   logic       Vsync;
   logic [7:0] Datos;
   logic       frame_done;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
   modport master (output Pclk, Href, Vsync, Datos, frame_done, frame_cnt);
   modport slave  (input  Pclk, Href, Vsync, Datos, frame_done, frame_cnt);
`else
   modport master (output Pclk, Href, Vsync, Datos, frame_done);
   modport slave  (input  Pclk, Href, Vsync, Datos, frame_done);
`endif
endinterface

// File: rtl/cam_stream_gen_pattern_rom.sv
// Combinational test-pattern generator: pixel (x, y) and latched pattern -> RGB565.
// The bar index is supplied by the caller's bar counter so no divider is needed.
// With CAM_STREAM_GEN_FRAME_CNT_EN the solid pattern shows the frame count in blue.
module cam_pattern_rom
   import cam_stream_gen_pkg::*;
(
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  bar,
   input  pat_t        pat,
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
   input  logic [4:0]  lvl,
`endif
   output logic [15:0] rgb
);

   // Low coordinate bits are not needed by any pattern.
   logic unused_bits;
   assign unused_bits = ^{x[2:0], y[0]};

   // Pattern select.
   always_comb begin
      rgb = RGB_BLACK;
      case (pat)
         PAT_BARS:  rgb = bar_color(bar);
         PAT_GRAD:  rgb = {x[7:3], y[6:1], 5'd0};
         PAT_CHECK: rgb = (x[3] ^ y[3]) ? RGB_WHITE : RGB_BLACK;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
         PAT_SOLID: rgb = {11'd0, lvl};
`else
         PAT_SOLID: rgb = RGB_RED;
`endif
         default:   rgb = RGB_BLACK;
      endcase
   end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style QQVGA RGB565 stream transmitter with built-in test patterns.
// Pclk = clk/2; all timing state advances only on "slot" edges (ph==1), so
// Href/Vsync/Datos change as Pclk falls and are stable across its rising edge.
// Optional: CAM_STREAM_GEN_FRAME_CNT_EN adds a 16-bit frame counter output.
module cam_stream_gen
   import cam_stream_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE     = 160,
   parameter int unsigned V_ACTIVE     = 120,
   parameter int unsigned H_BLANK      = 64,
   parameter int unsigned VSYNC_LINES  = 3,
   parameter int unsigned VBACK_LINES  = 17,
   parameter int unsigned VFRONT_LINES = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   cam_stream_gen_if.master cam
);

   localparam int unsigned LT        = 2 * H_ACTIVE + H_BLANK;
   localparam logic [8:0]  SLOT_LAST = 9'(LT - 1);
   localparam logic [8:0]  ACT_BYTES = 9'(2 * H_ACTIVE);
   localparam logic [4:0]  VS_LAST   = 5'(VSYNC_LINES - 1);
   localparam logic [4:0]  VB_LAST   = 5'(VBACK_LINES - 1);
   localparam logic [4:0]  VF_LAST   = 5'(VFRONT_LINES - 1);
   localparam logic [6:0]  Y_LAST    = 7'(V_ACTIVE - 1);
   localparam logic [4:0]  BAR_LAST  = 5'(H_ACTIVE / 8 - 1);

   logic        ph;
   state_t      state, state_n;
   logic [8:0]  hcnt, hcnt_n;
   logic [4:0]  lcnt, lcnt_n;
   logic [6:0]  y, y_n;
   logic [2:0]  bar, bar_n;
   logic [4:0]  bcnt, bcnt_n;
   pat_t        pat_q, pat_n;
   logic        done_n;
   logic        frame_done_q;
   logic        line_end;
   logic [7:0]  x;
   logic [15:0] rgb;
   logic        href;
   logic        vsync;
   logic [7:0]  datos;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   assign line_end = (hcnt == SLOT_LAST);
   assign x        = hcnt[8:1];

   // State register: phase bit, FSM state, counters, latched pattern, done strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph           <= 1'b0;
         state        <= ST_IDLE;
         hcnt         <= '0;
         lcnt         <= '0;
         y            <= '0;
         bar          <= '0;
         bcnt         <= '0;
         pat_q        <= PAT_BARS;
         frame_done_q <= 1'b0;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
         frame_cnt    <= '0;
`endif
      end else begin
         ph           <= ~ph;
         state        <= state_n;
         hcnt         <= hcnt_n;
         lcnt         <= lcnt_n;
         y            <= y_n;
         bar          <= bar_n;
         bcnt         <= bcnt_n;
         pat_q        <= pat_n;
         frame_done_q <= done_n;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
         if (done_n)
            frame_cnt <= frame_cnt + 16'd1;
`endif
      end
   end

   // Next-state logic: everything holds except on slot edges (ph==1).
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      lcnt_n  = lcnt;
      y_n     = y;
      bar_n   = bar;
      bcnt_n  = bcnt;
      pat_n   = pat_q;
      done_n  = 1'b0;
      if (ph) begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state_n = ST_VSYNC;
                  hcnt_n  = '0;
                  lcnt_n  = '0;
                  pat_n   = pat_t'(pattern_sel);
               end
            end
            ST_VSYNC: begin
               if (line_end) begin
                  hcnt_n = '0;
                  if (lcnt == VS_LAST) begin
                     lcnt_n  = '0;
                     state_n = ST_VBACK;
                  end else begin
                     lcnt_n = lcnt + 5'd1;
                  end
               end else begin
                  hcnt_n = hcnt + 9'd1;
               end
            end
            ST_VBACK: begin
               if (line_end) begin
                  hcnt_n = '0;
                  if (lcnt == VB_LAST) begin
                     lcnt_n  = '0;
                     y_n     = '0;
                     bar_n   = '0;
                     bcnt_n  = '0;
                     state_n = ST_ACTIVE;
                  end else begin
                     lcnt_n = lcnt + 5'd1;
                  end
               end else begin
                  hcnt_n = hcnt + 9'd1;
               end
            end
            ST_ACTIVE: begin
               if (line_end) begin
                  hcnt_n = '0;
                  bar_n  = '0;
                  bcnt_n = '0;
                  if (y == Y_LAST) begin
                     lcnt_n  = '0;
                     state_n = ST_VFRONT;
                  end else begin
                     y_n = y + 7'd1;
                  end
               end else begin
                  hcnt_n = hcnt + 9'd1;
                  // Leaving the odd byte of a pixel: step the bar counter,
                  // saturating on the last bar so it never wraps mid-line.
                  if (hcnt[0] && (hcnt < ACT_BYTES)) begin
                     if (bcnt == BAR_LAST) begin
                        bcnt_n = '0;
                        if (bar != 3'd7)
                           bar_n = bar + 3'd1;
                     end else begin
                        bcnt_n = bcnt + 5'd1;
                     end
                  end
               end
            end
            ST_VFRONT: begin
               if (line_end) begin
                  hcnt_n = '0;
                  if (lcnt == VF_LAST) begin
                     lcnt_n = '0;
                     done_n = 1'b1;
                     if (enable) begin
                        state_n = ST_VSYNC;
                        pat_n   = pat_t'(pattern_sel);
                     end else begin
                        state_n = ST_IDLE;
                     end
                  end else begin
                     lcnt_n = lcnt + 5'd1;
                  end
               end else begin
                  hcnt_n = hcnt + 9'd1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   cam_pattern_rom u_rom (
      .x   (x),
      .y   (y),
      .bar (bar),
      .pat (pat_q),
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
      .lvl (frame_cnt[4:0]),
`endif
      .rgb (rgb)
   );

   // Output decode from registered state: sync levels and the byte mux.
   always_comb begin
      href  = (state == ST_ACTIVE) && (hcnt < ACT_BYTES);
      vsync = (state == ST_VSYNC);
      datos = href ? rgb_byte(rgb, hcnt[0]) : 8'd0;
   end

   assign cam.Pclk       = ph;
   assign cam.Href       = href;
   assign cam.Vsync      = vsync;
   assign cam.Datos      = datos;
   assign cam.frame_done = frame_done_q;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
   assign cam.frame_cnt  = frame_cnt;
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with reduced geometry (16x16, LT=40 slots,
// 23 lines, 1840 clk per frame). A negedge monitor measures sync timing and
// captures each frame's bytes; the main sequence checks them against
// hand-computed values. Honours CAM_STREAM_GEN_FRAME_CNT_EN.
module tb_cam_stream_gen;

   localparam int unsigned HA = 16;
   localparam int unsigned VA = 16;
   localparam int unsigned HB = 8;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 3;
   localparam int unsigned VF = 2;
   localparam int unsigned LT = 2 * HA + HB;
   localparam int unsigned FRAME_CLK = (VS + VB + VA + VF) * LT * 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] pattern_sel;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   cam_stream_gen_if cam ();

   cam_stream_gen #(
      .H_ACTIVE     (HA),
      .V_ACTIVE     (VA),
      .H_BLANK      (HB),
      .VSYNC_LINES  (VS),
      .VBACK_LINES  (VB),
      .VFRONT_LINES (VF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .cam         (cam)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int unsigned cyc = 0;
   logic pclk_prev = 1'b0, vs_prev = 1'b0, href_prev = 1'b0, fd_prev = 1'b0;
   int unsigned vs_slots = 0, vb_slots = 0, lines = 0, bad_lines = 0, byte_idx = 0;
   int unsigned vs_rises = 0, vs_rise_cyc = 0, viol = 0, done_cnt = 0, fd_high = 0;
   bit got_href = 1'b0;
   int unsigned last_len = 0, last_vs = 0, last_vb = 0, last_lines = 0, last_bad = 0;
   logic [7:0] mem      [VA][2*HA];
   logic [7:0] last_mem [VA][2*HA];

   always @(negedge clk) begin
      cyc++;
      if (!cam.Href && cam.Datos != 8'd0) viol++;
      if (cam.frame_done) begin
         fd_high++;
         if (!fd_prev) begin
            done_cnt++;
            last_len   = cyc - vs_rise_cyc;
            last_vs    = vs_slots;
            last_vb    = vb_slots;
            last_lines = lines;
            last_bad   = bad_lines;
            last_mem   = mem;
         end
      end
      if (cam.Vsync && !vs_prev) begin
         vs_rises++;
         vs_rise_cyc = cyc;
         vs_slots = 0; vb_slots = 0; lines = 0; bad_lines = 0;
         byte_idx = 0; got_href = 1'b0;
      end
      if (cam.Pclk && !pclk_prev) begin
         if (cam.Vsync) vs_slots++;
         else if (!cam.Href && !got_href) vb_slots++;
         if (cam.Href) begin
            got_href = 1'b1;
            if (lines < VA && byte_idx < 2 * HA) mem[lines][byte_idx] = cam.Datos;
            byte_idx++;
         end
      end
      if (!cam.Href && href_prev) begin
         if (byte_idx != 2 * HA) bad_lines++;
         lines++;
         byte_idx = 0;
      end
      pclk_prev = cam.Pclk;
      vs_prev   = cam.Vsync;
      href_prev = cam.Href;
      fd_prev   = cam.frame_done;
   end

   function automatic logic [15:0] pix(input int unsigned ln, input int unsigned px);
      return {last_mem[ln][2*px], last_mem[ln][2*px+1]};
   endfunction

   task automatic wait_done(input int unsigned k);
      int unsigned n = 0;
      while (done_cnt < k && n < 2 * FRAME_CLK) begin
         @(posedge clk);
         n++;
      end
      check($sformatf("frame%0d_done_seen", k), 32'(done_cnt >= k), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_lines(input int unsigned k);
      int unsigned n = 0;
      while (lines < k && n < 2 * FRAME_CLK) begin
         @(posedge clk);
         n++;
      end
      check("mid_frame_reached", 32'(lines >= k), 32'd1);
   endtask

   task automatic check_geometry(input int unsigned k);
      check($sformatf("f%0d_len_clk", k), last_len, FRAME_CLK);
      check($sformatf("f%0d_vsync_slots", k), last_vs, VS * LT);
      check($sformatf("f%0d_vback_slots", k), last_vb, VB * LT);
      check($sformatf("f%0d_href_pulses", k), last_lines, VA);
      check($sformatf("f%0d_short_lines", k), last_bad, 0);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
      check($sformatf("f%0d_frame_cnt", k), 32'(cam.frame_cnt), k);
`endif
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("reset_outputs_%0d", i),
               {19'd0, cam.Pclk, cam.Href, cam.Vsync, cam.Datos, cam.frame_done}, 32'd0);
      end
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
      check("reset_frame_cnt", 32'(cam.frame_cnt), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("rel1_pclk_vsync", {30'd0, cam.Pclk, cam.Vsync}, 32'b10);
      @(negedge clk);
      check("rel2_pclk_vsync", {30'd0, cam.Pclk, cam.Vsync}, 32'b01);
      @(negedge clk);
      check("rel3_pclk", 32'(cam.Pclk), 32'd1);
      @(negedge clk);
      check("rel4_pclk", 32'(cam.Pclk), 32'd0);

      // Frame 1: bars; pattern_sel changes mid-frame must not leak in.
      wait_lines(4);
      pattern_sel = 2'd2;
      wait_done(1);
      check_geometry(1);
      check("bars_px0", pix(0, 0), 16'hFFFF);
      check("bars_px2", pix(0, 2), 16'hFFE0);
      check("bars_px4", pix(0, 4), 16'h07FF);
      check("bars_px10", pix(0, 10), 16'hF800);
      check("bars_px15", pix(0, 15), 16'h0000);
      check("bars_late_line_px3", pix(15, 3), 16'hFFE0);
      check("datos_zero_off_href", viol, 0);

      // Frame 2: checkerboard.
      wait_lines(4);
      pattern_sel = 2'd1;
      wait_done(2);
      check_geometry(2);
      check("chk_8_0", pix(0, 8), 16'hFFFF);
      check("chk_0_0", pix(0, 0), 16'h0000);
      check("chk_8_8", pix(8, 8), 16'h0000);
      check("chk_0_8", pix(8, 0), 16'hFFFF);

      // Frame 3: gradient.
      wait_lines(4);
      pattern_sel = 2'd3;
      wait_done(3);
      check_geometry(3);
      check("grad_9_5", pix(5, 9), 16'h0840);
      check("grad_0_15", pix(15, 0), 16'h00E0);
      check("grad_15_0", pix(0, 15), 16'h0800);

      // Frame 4: solid; drop enable and change pattern mid-frame.
      wait_lines(4);
      enable = 1'b0;
      pattern_sel = 2'd0;
      wait_done(4);
      check_geometry(4);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
      check("solid_5_3", pix(3, 5), 16'h0003);
      check("solid_15_15", pix(15, 15), 16'h0003);
`else
      check("solid_5_3", pix(3, 5), 16'hF800);
      check("solid_15_15", pix(15, 15), 16'hF800);
`endif

      // Idle after the last frame.
      repeat (300) @(negedge clk);
      check("idle_vsync_rises", vs_rises, 4);
      check("idle_done_count", done_cnt, 4);
      check("idle_href_vsync", {30'd0, cam.Href, cam.Vsync}, 32'd0);
      check("done_pulse_width", fd_high, 4);
      check("datos_zero_off_href_end", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
